// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter (reverse double dabble).
// One shift+correct step per clock behind a start/busy/done handshake; an
// invalid digit still takes the full latency but yields 0 with o_invalid set.
module bcd_to_binary #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_WIDTH  = 14
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [4*NUM_DIGITS-1:0] i_bcd_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BIN_WIDTH-1:0]    o_binary_data,
  output logic                    o_invalid
);

  localparam int unsigned SR_W  = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (SR_W > 2) ? $clog2(SR_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SR_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    bcd_q, bcd_d;
  logic [SR_W-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               busy_d;
  logic               done_d;
  logic [BIN_WIDTH-1:0] result_d;
  logic               invalid_d;
  logic [2*SR_W-1:0]  step_c;

  // True when any packed digit is outside 0..9.
  function automatic logic has_bad_digit(input logic [SR_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // One reverse double-dabble step: shift {bcd,bin} right, then take 3 off
  // every BCD digit that landed at 8 or above.
  function automatic logic [2*SR_W-1:0] dabble_step(input logic [SR_W-1:0] bcd,
                                                    input logic [SR_W-1:0] bin);
    logic [2*SR_W-1:0] s;
    logic [3:0]        digit;
    s = {bcd, bin} >> 1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      digit = s[SR_W + 4*d +: 4];
      if (digit >= 4'd8) begin
        s[SR_W + 4*d +: 4] = digit - 4'd3;
      end
    end
    return s;
  endfunction

  // Combinational step of the shift/correct datapath.
  assign step_c = dabble_step(bcd_q, bin_q);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    busy_d    = o_busy;
    done_d    = 1'b0;
    result_d  = o_binary_data;
    invalid_d = o_invalid;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          bcd_d   = i_bcd_data;
          bin_d   = '0;
          cnt_d   = '0;
          err_d   = has_bad_digit(i_bcd_data);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        bcd_d  = step_c[2*SR_W-1:SR_W];
        bin_d  = step_c[SR_W-1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        result_d  = err_q ? '0 : BIN_WIDTH'(bin_q);
        invalid_d = err_q;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any conversion.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      bcd_q         <= '0;
      bin_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_binary_data <= '0;
      o_invalid     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bcd_q         <= bcd_d;
      bin_q         <= bin_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      o_busy        <= busy_d;
      o_done        <= done_d;
      o_binary_data <= result_d;
      o_invalid     <= invalid_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: decimal-arithmetic reference model checked every
// cycle, plus directed conversions with hand-computed expectations.
module tb_bcd_to_binary;

  localparam int unsigned ND  = 4;
  localparam int unsigned BW  = 14;
  localparam int          LAT = 4 * ND + 1;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [15:0]   i_bcd_data = 16'h0;
  logic          o_busy;
  logic          o_done;
  logic [BW-1:0] o_binary_data;
  logic          o_invalid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int cyc    = 0;

  bcd_to_binary #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_bcd_data    (i_bcd_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_binary_data (o_binary_data),
    .o_invalid     (o_invalid)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word; invalid words map to 0.
  function automatic void ref_convert(input logic [15:0] b, output int val, output logic inv);
    logic [15:0] w;
    int dig;
    w = b;
    val = 0;
    inv = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      dig = int'(w[4*d +: 4]);
      if (dig > 9) inv = 1'b1;
      val = val * 10 + dig;
    end
    if (inv) val = 0;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: a request accepted while idle completes LAT edges later.
  int   remain   = 0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;
  logic exp_inv  = 1'b0;
  logic pend_inv = 1'b0;
  int   exp_bin  = 0;
  int   pend_bin = 0;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      remain   = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_inv  = 1'b0;
      exp_bin  = 0;
    end else begin
      exp_done = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          exp_done = 1'b1;
          exp_busy = 1'b0;
          exp_bin  = pend_bin;
          exp_inv  = pend_inv;
        end
      end else if (i_start) begin
        ref_convert(i_bcd_data, pend_bin, pend_inv);
        remain   = LAT;
        exp_busy = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("busy", 32'(o_busy), 32'(exp_busy));
      chk("done", 32'(o_done), 32'(exp_done));
      chk("binary", 32'(o_binary_data), 32'(exp_bin));
      chk("invalid", 32'(o_invalid), 32'(exp_inv));
    end
  end

  // Request one conversion (called at a falling edge) and wait for o_done.
  task automatic run(input logic [15:0] bcd, input int inject_at,
                     output int lat, output int bin, output logic inv);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    bin = -1;
    inv = 1'bx;
    i_start    = 1'b1;
    i_bcd_data = bcd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      i_start    = 1'b0;
      i_bcd_data = 16'($urandom);
      if (k == inject_at) begin
        i_start    = 1'b1;
        i_bcd_data = 16'h5555;
      end
      if (o_done) begin
        lat = k;
        bin = int'(o_binary_data);
        inv = o_invalid;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      if (o_done) cnt++;
    end
  endtask

  int   lat, bin, nd, t0, t1, t2;
  logic inv;
  logic [15:0] bad_pat [4] = '{16'hA000, 16'h0F00, 16'h00B0, 16'h000C};

  initial begin
    #1 i_reset = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_binary", 32'(o_binary_data), 32'd0);
    chk("rst_invalid", 32'(o_invalid), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Zero input and latency.
    run(16'h0000, 0, lat, bin, inv);
    chk("t1_latency", 32'(lat), 32'd18);
    chk("t1_binary", 32'(bin), 32'd0);
    chk("t1_invalid", 32'(inv), 32'd0);
    @(negedge i_clk);
    chk("t1_done_width", 32'(o_done), 32'd0);

    // Full-scale and mixed values.
    run(16'h9999, 0, lat, bin, inv);
    chk("t2_9999", 32'(bin), 32'h270F);
    chk("t2_9999_inv", 32'(inv), 32'd0);
    @(negedge i_clk);
    chk("t2_done_width", 32'(o_done), 32'd0);
    chk("t2_busy_after", 32'(o_busy), 32'd0);
    run(16'h1234, 0, lat, bin, inv);
    chk("t2_1234", 32'(bin), 32'h04D2);

    // Invalid digit, then recovery.
    run(16'h12A4, 0, lat, bin, inv);
    chk("t3_bad_latency", 32'(lat), 32'd18);
    chk("t3_bad_binary", 32'(bin), 32'd0);
    chk("t3_bad_invalid", 32'(inv), 32'd1);
    run(16'h0042, 0, lat, bin, inv);
    chk("t3_0042", 32'(bin), 32'd42);
    chk("t3_0042_inv", 32'(inv), 32'd0);

    // Start while busy is ignored.
    run(16'h0100, 5, lat, bin, inv);
    chk("t4_0100", 32'(bin), 32'd100);
    chk("t4_latency", 32'(lat), 32'd18);
    count_dones(25, nd);
    chk("t4_extra_done", 32'(nd), 32'd0);

    // Asynchronous reset mid-conversion.
    i_start    = 1'b1;
    i_bcd_data = 16'h0777;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (7) @(negedge i_clk);
    chk("t5_busy_before", 32'(o_busy), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(o_busy), 32'd0);
    chk("t5_rst_binary", 32'(o_binary_data), 32'd0);
    chk("t5_rst_done", 32'(o_done), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    count_dones(25, nd);
    chk("t5_no_done", 32'(nd), 32'd0);
    run(16'h0777, 0, lat, bin, inv);
    chk("t5_0777", 32'(bin), 32'd777);

    // Back-to-back starts.
    run(16'h0007, 0, lat, bin, inv);
    t0 = cyc;
    chk("t6_0007", 32'(bin), 32'd7);
    run(16'h0010, 0, lat, bin, inv);
    t1 = cyc;
    chk("t6_0010", 32'(bin), 32'd10);
    run(16'h0999, 0, lat, bin, inv);
    t2 = cyc;
    chk("t6_0999", 32'(bin), 32'd999);
    chk("t6_spacing1", 32'(t1 - t0), 32'd18);
    chk("t6_spacing2", 32'(t2 - t1), 32'd18);

    // Invalid patterns in every digit position.
    foreach (bad_pat[i]) begin
      run(bad_pat[i], 0, lat, bin, inv);
      chk("bad_pat_inv", 32'(inv), 32'd1);
      chk("bad_pat_bin", 32'(bin), 32'd0);
    end

    // Strided sweep of the valid range.
    for (int v = 0; v < 10000; v += 7) begin
      run(to_bcd(v), 0, lat, bin, inv);
      chk("sweep", 32'(bin), 32'(v));
    end
    run(to_bcd(9998), 0, lat, bin, inv);
    chk("sweep_9998", 32'(bin), 32'd9998);

    repeat (3) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
